i2c_txn_arbiter: RTL and testbench
==================================

// Module: i2c_txn_arbiter
// PURPOSE
//  Shares one byte-level I2C master engine among N requesters (config FSMs, sensor pollers, CPU regs).
//  Arbitrates round-robin and latches the winner's command. Issues it to the master, retries on NACK,
//  watchdogs for timeouts, then returns read data and status to the granted requester. Sits between
//  requesters and the I2C master; owns o_m_start exclusively.
// PARAMETERS
//  N_REQ        3      number of requesters (2..8)
//  MAX_RETRY    2      extra attempts after a NACK (0 = no retry)
//  RETRY_GAP    1000   i_clk cycles idle between NACK and retry (bus free time)
//  TIMEOUT_CYC  65535  i_clk cycles in WAIT before abort; 16-bit counter
// PORTS
//  i_clk      in   1          system clock
//  i_rst_n    in   1          async active-low reset
//  i_req      in   N_REQ      per-requester request level; held until o_done
//  i_rw       in   N_REQ      1 = read (current-address), 0 = write
//  i_addr     in   7*N_REQ    7-bit slave address per requester, req k at [7k+6:7k]
//  i_word     in   8*N_REQ    word address per requester (write only)
//  i_wdata    in   8*N_REQ    write byte per requester
//  o_gnt      out  N_REQ      one-hot grant, high from latch through RESP cycle
//  o_done     out  N_REQ      1-cycle completion pulse to granted requester
//  o_status   out  2          00 OK, 01 NACK (retries exhausted), 10 TIMEOUT; valid with o_done
//  o_rdata    out  8          read byte; valid with o_done when i_rw=1 and status OK
//  o_m_start  out  1          1-cycle command strobe to master
//  o_m_rw     out  1          latched rw
//  o_m_addr   out  7          latched slave address
//  o_m_word   out  8          latched word address
//  o_m_wdata  out  8          latched write byte
//  i_m_busy   in   1          master not in idle
//  i_m_done   in   1          1-cycle: master finished (STOP sent or aborted to idle)
//  i_m_nack   in   1          valid with i_m_done: an ACK slot saw SDA high
//  i_m_rdata  in   8          valid with i_m_done on reads
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; rr pointer 0; retry/timeout/gap counters 0. Async assert, sync release.
//  FSM: IDLE -> ISSUE -> WAIT -> {GAP -> ISSUE | RESP} -> IDLE.
//   IDLE: if |i_req, pick first set bit at or after ptr (wrap). Latch its rw/addr/word/wdata into o_m_*.
//    Set o_gnt one-hot and go ISSUE. o_gnt is visible the cycle after i_req is seen.
//   ISSUE: wait while i_m_busy. When ~i_m_busy, pulse o_m_start for 1 cycle, clear timeout count, go WAIT.
//   WAIT: timeout count +1 per cycle.
//    On i_m_done with ~i_m_nack: status OK, capture i_m_rdata, go RESP.
//    On i_m_done with i_m_nack: if retry_cnt < MAX_RETRY, increment retry_cnt and go GAP.
//    Otherwise status NACK and go RESP.
//    If count reaches TIMEOUT_CYC-1 with no done: status TIMEOUT, go RESP. The master is not reset here.
//    i_m_done in the same cycle as timeout: done wins.
//   GAP: count RETRY_GAP cycles, then ISSUE with the same latched command.
//   RESP: o_done[idx]=1 for exactly this cycle, with o_status/o_rdata stable. Next cycle: o_gnt=0,
//    ptr=idx+1 mod N_REQ, retry_cnt=0, go IDLE. o_status/o_rdata hold until the next RESP.
//  Requests are sampled only in IDLE. Dropping i_req after grant does not abort; o_done is still pulsed.
//  Requester re-asserting in the cycle after RESP is considered only after all others (fairness).
//  Back-to-back: min 2 idle cycles between o_done and next o_m_start.
//  o_rdata is 0 on write completions. o_m_* are unchanged between grants.
//  Unexpected i_m_done outside WAIT: ignored.
//  Reset mid-transaction: master-side command is dropped; requester must re-request.
// STRUCTURE
//  Package i2c_pkg: FSM state enum (3-bit), status codes ST_OK/ST_NACK/ST_TIMEOUT, I2C_ADDR_W=7, I2C_BYTE_W=8.
//  Sub-module rr_arbiter_onehot (N, i_req, i_ptr -> o_gnt_onehot, o_idx): purely combinational,
//  reusable. Counters and FSM live in this module.
// TESTING  (N_REQ=3, MAX_RETRY=2, RETRY_GAP=16, TIMEOUT_CYC=200, behavioral master model)
//  1 Single write: req0 rw=0 addr=0x50 word=0x00 wdata=0xC0 -> one o_m_start with those fields.
//    Done arrives 40 cycles later -> o_done=3'b001, o_status=00, o_rdata=0x00.
//  2 Read: req1 rw=1 addr=0x50, model returns 0xA5 -> o_done=3'b010, o_status=00, o_rdata=0xA5.
//  3 Round robin: i_req=3'b111 held -> grant order 0,1,2,0. Exactly one o_gnt bit set at any time.
//  4 NACK retry: model NACKs twice then ACKs -> 3 o_m_start pulses, each >=16 cycles after prior done.
//    Final status 00. If NACK 3 times -> 3 starts, o_status=01.
//  5 Timeout: model never asserts done -> o_done pulse exactly 200 cycles after o_m_start, o_status=10.
//    Next request still served.
//  6 Reset mid-WAIT: assert i_rst_n=0 -> o_gnt, o_done, o_m_start = 0 immediately, async.
//    After release, new req2 granted first attempt with retry_cnt=0.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types for the I2C transaction arbiter: FSM states, completion status codes, field widths.
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_BYTE_W = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_GAP   = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    ST_OK      = 2'b00,
    ST_NACK    = 2'b01,
    ST_TIMEOUT = 2'b10
  } status_t;

endpackage

// File: rtl/rr_arbiter_onehot.sv
// Combinational round-robin picker: first set request at or after i_ptr, wrapping modulo N.
module rr_arbiter_onehot #(
  parameter int N     = 3,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_gnt_onehot,
  output logic [IDX_W-1:0] o_idx
);

  int   cand;
  logic found;

  always_comb begin
    o_gnt_onehot = '0;
    o_idx        = '0;
    found        = 1'b0;
    cand         = 0;
    for (int i = 0; i < N; i++) begin
      // ptr + i never exceeds 2N-2, so one conditional subtract wraps it.
      cand = int'(i_ptr) + i;
      if (cand >= N) cand = cand - N;
      if (!found && i_req[cand]) begin
        found              = 1'b1;
        o_gnt_onehot[cand] = 1'b1;
        o_idx              = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// Shares one byte-level I2C master among N_REQ requesters: round-robin grant, command latch,
// NACK retry with bus-free gap, WAIT watchdog, and status/read-data return to the winner.
module i2c_txn_arbiter
  import i2c_pkg::*;
#(
  parameter int N_REQ       = 3,
  parameter int MAX_RETRY   = 2,
  parameter int RETRY_GAP   = 1000,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic [N_REQ-1:0]            i_req,
  input  logic [N_REQ-1:0]            i_rw,
  input  logic [I2C_ADDR_W*N_REQ-1:0] i_addr,
  input  logic [I2C_BYTE_W*N_REQ-1:0] i_word,
  input  logic [I2C_BYTE_W*N_REQ-1:0] i_wdata,
  output logic [N_REQ-1:0]            o_gnt,
  output logic [N_REQ-1:0]            o_done,
  output logic [1:0]                  o_status,
  output logic [I2C_BYTE_W-1:0]       o_rdata,
  output logic                        o_m_start,
  output logic                        o_m_rw,
  output logic [I2C_ADDR_W-1:0]       o_m_addr,
  output logic [I2C_BYTE_W-1:0]       o_m_word,
  output logic [I2C_BYTE_W-1:0]       o_m_wdata,
  input  logic                        i_m_busy,
  input  logic                        i_m_done,
  input  logic                        i_m_nack,
  input  logic [I2C_BYTE_W-1:0]       i_m_rdata
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int RTY_W = $clog2(MAX_RETRY + 2);
  localparam int GAP_W = $clog2(RETRY_GAP + 1);
  localparam int TMO_W = 16;

  state_t                  state;
  logic [IDX_W-1:0]        ptr;
  logic [IDX_W-1:0]        idx_q;
  logic [RTY_W-1:0]        retry_cnt;
  logic [GAP_W-1:0]        gap_cnt;
  logic [TMO_W-1:0]        tmo_cnt;

  logic [N_REQ-1:0]        arb_gnt;
  logic [IDX_W-1:0]        arb_idx;
  logic                    sel_rw;
  logic [I2C_ADDR_W-1:0]   sel_addr;
  logic [I2C_BYTE_W-1:0]   sel_word;
  logic [I2C_BYTE_W-1:0]   sel_wdata;

  rr_arbiter_onehot #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .i_req        (i_req),
    .i_ptr        (ptr),
    .o_gnt_onehot (arb_gnt),
    .o_idx        (arb_idx)
  );

  // The one-hot grant doubles as the field-select, so no index arithmetic is needed here.
  always_comb begin
    sel_rw    = 1'b0;
    sel_addr  = '0;
    sel_word  = '0;
    sel_wdata = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (arb_gnt[k]) begin
        sel_rw    = i_rw[k];
        sel_addr  = i_addr[k*I2C_ADDR_W +: I2C_ADDR_W];
        sel_word  = i_word[k*I2C_BYTE_W +: I2C_BYTE_W];
        sel_wdata = i_wdata[k*I2C_BYTE_W +: I2C_BYTE_W];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= S_IDLE;
      ptr       <= '0;
      idx_q     <= '0;
      retry_cnt <= '0;
      gap_cnt   <= '0;
      tmo_cnt   <= '0;
      o_gnt     <= '0;
      o_done    <= '0;
      o_status  <= ST_OK;
      o_rdata   <= '0;
      o_m_start <= 1'b0;
      o_m_rw    <= 1'b0;
      o_m_addr  <= '0;
      o_m_word  <= '0;
      o_m_wdata <= '0;
    end else begin
      o_m_start <= 1'b0;
      o_done    <= '0;
      case (state)
        S_IDLE: begin
          if (|i_req) begin
            o_gnt     <= arb_gnt;
            idx_q     <= arb_idx;
            o_m_rw    <= sel_rw;
            o_m_addr  <= sel_addr;
            o_m_word  <= sel_word;
            o_m_wdata <= sel_wdata;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!i_m_busy) begin
            o_m_start <= 1'b1;
            tmo_cnt   <= '0;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A done that coincides with the last watchdog cycle takes priority.
          if (i_m_done) begin
            if (!i_m_nack) begin
              o_status <= ST_OK;
              o_rdata  <= o_m_rw ? i_m_rdata : '0;
              o_done   <= o_gnt;
              state    <= S_RESP;
            end else if (retry_cnt < RTY_W'(MAX_RETRY)) begin
              retry_cnt <= retry_cnt + 1'b1;
              gap_cnt   <= '0;
              state     <= S_GAP;
            end else begin
              o_status <= ST_NACK;
              o_rdata  <= '0;
              o_done   <= o_gnt;
              state    <= S_RESP;
            end
          end else if (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
            o_status <= ST_TIMEOUT;
            o_rdata  <= '0;
            o_done   <= o_gnt;
            state    <= S_RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_W'(RETRY_GAP - 1)) state <= S_ISSUE;
          else gap_cnt <= gap_cnt + 1'b1;
        end
        S_RESP: begin
          o_gnt     <= '0;
          ptr       <= (idx_q == IDX_W'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
          retry_cnt <= '0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Directed bench for i2c_txn_arbiter with a behavioural byte-level master and a completion scoreboard.
module tb_i2c_txn_arbiter;
  import i2c_pkg::*;

  localparam int N_REQ       = 3;
  localparam int MAX_RETRY   = 2;
  localparam int RETRY_GAP   = 16;
  localparam int TIMEOUT_CYC = 200;

  logic              clk;
  logic              rst_n;
  logic [2:0]        i_req;
  logic [2:0]        i_rw;
  logic [20:0]       i_addr;
  logic [23:0]       i_word;
  logic [23:0]       i_wdata;
  logic [2:0]        o_gnt;
  logic [2:0]        o_done;
  logic [1:0]        o_status;
  logic [7:0]        o_rdata;
  logic              o_m_start;
  logic              o_m_rw;
  logic [6:0]        o_m_addr;
  logic [7:0]        o_m_word;
  logic [7:0]        o_m_wdata;
  logic              i_m_busy;
  logic              i_m_done;
  logic              i_m_nack;
  logic [7:0]        i_m_rdata;

  i2c_txn_arbiter #(
    .N_REQ       (N_REQ),
    .MAX_RETRY   (MAX_RETRY),
    .RETRY_GAP   (RETRY_GAP),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_req     (i_req),
    .i_rw      (i_rw),
    .i_addr    (i_addr),
    .i_word    (i_word),
    .i_wdata   (i_wdata),
    .o_gnt     (o_gnt),
    .o_done    (o_done),
    .o_status  (o_status),
    .o_rdata   (o_rdata),
    .o_m_start (o_m_start),
    .o_m_rw    (o_m_rw),
    .o_m_addr  (o_m_addr),
    .o_m_word  (o_m_word),
    .o_m_wdata (o_m_wdata),
    .i_m_busy  (i_m_busy),
    .i_m_done  (i_m_done),
    .i_m_nack  (i_m_nack),
    .i_m_rdata (i_m_rdata)
  );

  // clock / cycle counter
  int cyc;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // master model: knobs written by the main sequence, state owned by this process
  int          m_lat        = 10;
  bit          m_hang       = 1'b0;
  logic [7:0]  m_rdata      = 8'h00;
  int          m_nack_limit = 0;
  int          m_nacks_given;
  int          m_cnt;
  logic [23:0] start_q[$];
  int          start_cyc_q[$];
  int          nack_cyc_q[$];

  initial begin
    i_m_busy      = 1'b0;
    i_m_done      = 1'b0;
    i_m_nack      = 1'b0;
    i_m_rdata     = 8'h00;
    m_nacks_given = 0;
    m_cnt         = 0;
    forever begin
      @(negedge clk);
      i_m_done = 1'b0;
      i_m_nack = 1'b0;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          i_m_done  = 1'b1;
          i_m_busy  = 1'b0;
          i_m_rdata = m_rdata;
          if (m_nacks_given < m_nack_limit) begin
            i_m_nack = 1'b1;
            m_nacks_given++;
            nack_cyc_q.push_back(cyc);
          end
        end
      end else if (i_m_busy && !m_hang) begin
        i_m_busy = 1'b0;
      end
      if (o_m_start) begin
        start_q.push_back({o_m_rw, o_m_addr, o_m_word, o_m_wdata});
        start_cyc_q.push_back(cyc);
        i_m_busy = 1'b1;
        m_cnt    = m_hang ? 0 : m_lat;
      end
    end
  end

  // grant one-hot monitor
  int gnt_bad = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && !$onehot0(o_gnt)) gnt_bad++;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_watchdog observed=stuck expected=finish");
    $fatal(1, "bench watchdog expired");
  end

  // scoreboard: {o_done, o_status, o_rdata}
  logic [12:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input int k, input logic rw, input logic [6:0] a,
                           input logic [7:0] w, input logic [7:0] d);
    i_rw[k]          = rw;
    i_addr[k*7 +: 7] = a;
    i_word[k*8 +: 8] = w;
    i_wdata[k*8 +: 8] = d;
  endtask

  task automatic check_done(input string tag, input int budget, output int at);
    logic [12:0] got;
    logic [12:0] exp;
    int n;
    got = '0;
    at  = -1;
    n   = 0;
    while (at < 0 && n < budget) begin
      @(negedge clk);
      if (o_done != 3'b000) begin
        got = {o_done, o_status, o_rdata};
        at  = cyc;
      end
      n++;
    end
    exp = 13'h1fff;
    if (exp_q.size() > 0) exp = exp_q.pop_front();
    chk({tag, "_seen"}, 32'(at >= 0), 32'd1);
    chk(tag, 32'(got), 32'(exp));
  endtask

  int s0, n0, at, prev_at, stray, n;

  initial begin
    rst_n   = 1'b0;
    i_req   = '0;
    i_rw    = '0;
    i_addr  = '0;
    i_word  = '0;
    i_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_gnt",    32'(o_gnt),     32'd0);
    chk("rst_done",   32'(o_done),    32'd0);
    chk("rst_start",  32'(o_m_start), 32'd0);
    chk("rst_status", 32'(o_status),  32'd0);
    chk("rst_rdata",  32'(o_rdata),   32'd0);
    chk("rst_maddr",  32'(o_m_addr),  32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // single write from requester 0
    m_lat = 40;
    drive_req(0, 1'b0, 7'h50, 8'h00, 8'hC0);
    exp_q.push_back({3'b001, ST_OK, 8'h00});
    s0 = start_q.size();
    i_req = 3'b001;
    @(negedge clk);
    chk("t1_gnt_next", 32'(o_gnt), 32'h1);
    check_done("t1_done", 200, at);
    i_req = 3'b000;
    chk("t1_starts", 32'(start_q.size() - s0), 32'd1);
    chk("t1_cmd", 32'(start_q[s0]), 32'({1'b0, 7'h50, 8'h00, 8'hC0}));
    chk("t1_latency", 32'(at - start_cyc_q[s0]), 32'd41);

    // read from requester 1
    m_lat   = 20;
    m_rdata = 8'hA5;
    drive_req(1, 1'b1, 7'h50, 8'h00, 8'h00);
    exp_q.push_back({3'b010, ST_OK, 8'hA5});
    s0 = start_q.size();
    i_req = 3'b010;
    check_done("t2_read", 200, at);
    i_req = 3'b000;
    chk("t2_cmd", 32'(start_q[s0]), 32'({1'b1, 7'h50, 8'h00, 8'h00}));

    // write from requester 2 while master still returns A5: rdata must read 0
    m_lat = 6;
    drive_req(2, 1'b0, 7'h3C, 8'h12, 8'h34);
    exp_q.push_back({3'b100, ST_OK, 8'h00});
    s0 = start_q.size();
    i_req = 3'b100;
    check_done("t2b_write", 200, at);
    i_req = 3'b000;
    chk("t2b_cmd", 32'(start_q[s0]), 32'({1'b0, 7'h3C, 8'h12, 8'h34}));

    // round robin with all requests held
    m_lat = 5;
    drive_req(0, 1'b0, 7'h11, 8'h01, 8'h0A);
    drive_req(1, 1'b0, 7'h22, 8'h02, 8'h0B);
    drive_req(2, 1'b0, 7'h33, 8'h03, 8'h0C);
    exp_q.push_back({3'b001, ST_OK, 8'h00});
    exp_q.push_back({3'b010, ST_OK, 8'h00});
    exp_q.push_back({3'b100, ST_OK, 8'h00});
    exp_q.push_back({3'b001, ST_OK, 8'h00});
    s0 = start_q.size();
    prev_at = -1;
    i_req = 3'b111;
    for (int i = 0; i < 4; i++) begin
      check_done($sformatf("t3_rr%0d", i), 200, at);
      if (i == 3) i_req = 3'b000;
      if (i > 0)
        chk($sformatf("t3_b2b%0d", i), 32'((start_cyc_q[s0+i] - prev_at) >= 3), 32'd1);
      prev_at = at;
    end
    chk("t3_starts", 32'(start_q.size() - s0), 32'd4);
    chk("t3_cmd1", 32'(start_q[s0+1]), 32'({1'b0, 7'h22, 8'h02, 8'h0B}));

    // two NACKs then ACK on requester 1
    m_lat        = 10;
    m_nack_limit = m_nacks_given + 2;
    drive_req(1, 1'b0, 7'h44, 8'h05, 8'h66);
    exp_q.push_back({3'b010, ST_OK, 8'h00});
    s0 = start_q.size();
    n0 = nack_cyc_q.size();
    i_req = 3'b010;
    check_done("t4_retry_ok", 400, at);
    i_req = 3'b000;
    chk("t4_starts", 32'(start_q.size() - s0), 32'd3);
    for (int j = 0; j < 2; j++)
      chk($sformatf("t4_gap%0d", j),
          32'((start_cyc_q[s0+j+1] - nack_cyc_q[n0+j]) >= RETRY_GAP + 1), 32'd1);
    chk("t4_retry_cmd", 32'(start_q[s0+2]), 32'({1'b0, 7'h44, 8'h05, 8'h66}));

    // three NACKs on requester 2: retries exhausted
    m_nack_limit = m_nacks_given + 3;
    drive_req(2, 1'b0, 7'h45, 8'h06, 8'h77);
    exp_q.push_back({3'b100, ST_NACK, 8'h00});
    s0 = start_q.size();
    i_req = 3'b100;
    check_done("t4_nack", 400, at);
    i_req = 3'b000;
    chk("t4_nack_starts", 32'(start_q.size() - s0), 32'd3);

    // timeout on requester 0, then requester 1 still served
    m_hang = 1'b1;
    drive_req(0, 1'b1, 7'h46, 8'h00, 8'h00);
    exp_q.push_back({3'b001, ST_TIMEOUT, 8'h00});
    s0 = start_q.size();
    i_req = 3'b001;
    check_done("t5_timeout", 400, at);
    i_req = 3'b000;
    chk("t5_tmo_lat", 32'(at - start_cyc_q[s0]), 32'(TIMEOUT_CYC));
    m_hang = 1'b0;
    m_lat  = 8;
    drive_req(1, 1'b0, 7'h47, 8'h09, 8'h99);
    exp_q.push_back({3'b010, ST_OK, 8'h00});
    i_req = 3'b010;
    check_done("t5_after", 300, at);
    i_req = 3'b000;

    // reset in the first WAIT cycle
    m_lat = 100;
    drive_req(0, 1'b0, 7'h48, 8'h0A, 8'hAA);
    s0 = start_q.size();
    i_req = 3'b001;
    n = 0;
    while (start_q.size() == s0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t6_started", 32'(start_q.size() - s0), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_async_gnt",   32'(o_gnt),     32'd0);
    chk("t6_async_start", 32'(o_m_start), 32'd0);
    chk("t6_async_done",  32'(o_done),    32'd0);
    i_req = 3'b000;
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    n = 0;
    while (i_m_busy && n < 200) begin
      @(negedge clk);
      if (o_done != 3'b000) stray++;
      n++;
    end
    repeat (3) begin
      @(negedge clk);
      if (o_done != 3'b000) stray++;
    end
    chk("t6_master_idle", 32'(i_m_busy), 32'd0);
    chk("t6_stray_done_ignored", 32'(stray), 32'd0);
    m_lat        = 10;
    m_nack_limit = m_nacks_given;
    drive_req(2, 1'b0, 7'h49, 8'h0B, 8'hBB);
    exp_q.push_back({3'b100, ST_OK, 8'h00});
    s0 = start_q.size();
    i_req = 3'b100;
    @(negedge clk);
    chk("t6_gnt2", 32'(o_gnt), 32'h4);
    check_done("t6_after_reset", 200, at);
    i_req = 3'b000;
    chk("t6_first_attempt", 32'(start_q.size() - s0), 32'd1);

    repeat (3) @(negedge clk);
    chk("gnt_onehot", 32'(gnt_bad), 32'd0);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
